// File: rtl/bo_pkg.sv
// Shared select encodings, ALU op codes and frame-FSM states for the BO datapath.
package bo_pkg;

  localparam logic [1:0] SEL_RX    = 2'd0;
  localparam logic [1:0] SEL_RH    = 2'd1;
  localparam logic [1:0] SEL_RS    = 2'd2;
  localparam logic [1:0] SEL_CONST = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_OPA = 2'd1;
  localparam logic [1:0] WB_XIN = 2'd2;
  localparam logic [1:0] WB_SAT = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bo_alu.sv
// Combinational add/multiply with a double-width result, truncated and saturated views.
module bo_alu
  import bo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] trunc,
  output logic [WIDTH-1:0] sat,
  output logic             ovf
);

  logic [2*WIDTH-1:0] full;

  always_comb begin
    if (op == OP_MUL) full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    else              full = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
    ovf   = |full[2*WIDTH-1:WIDTH];
    trunc = full[WIDTH-1:0];
    sat   = ovf ? '1 : full[WIDTH-1:0];
  end

endmodule

// File: rtl/bo_datapath.sv
// Operative datapath: RX/RH/RS working registers, operand and write-back muxes,
// and a frame FSM that pulses done with the final result after LS_PER_FRAME loads.
module bo_datapath
  import bo_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned C0           = 3,
  parameter int unsigned C1           = 1,
  parameter int unsigned LS_PER_FRAME = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             lx,
  input  logic             ls,
  input  logic             lh,
  input  logic             hula,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(LS_PER_FRAME) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LS_PER_FRAME - 1);

  state_t state, state_n;
  logic [WIDTH-1:0] rx, rh, rs;
  logic [WIDTH-1:0] opa, opb, wdata;
  logic [WIDTH-1:0] alu_trunc, alu_sat;
  logic             alu_ovf;
  logic [CNT_W-1:0] ls_cnt;
  logic             complete, restart;

  always_comb begin
    case (m0)
      SEL_RX:  opa = rx;
      SEL_RH:  opa = rh;
      SEL_RS:  opa = rs;
      default: opa = WIDTH'(C0);
    endcase
    case (m1)
      SEL_RX:  opb = rx;
      SEL_RH:  opb = rh;
      SEL_RS:  opb = rs;
      default: opb = WIDTH'(C1);
    endcase
  end

  bo_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (opa),
    .b     (opb),
    .op    (hula),
    .trunc (alu_trunc),
    .sat   (alu_sat),
    .ovf   (alu_ovf)
  );

  always_comb begin
    case (m2)
      WB_ALU:  wdata = alu_trunc;
      WB_OPA:  wdata = opa;
      WB_XIN:  wdata = x_in;
      default: wdata = alu_sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A completing ls takes priority over an lx restart in the same RUN cycle.
  always_comb begin
    state_n  = state;
    complete = 1'b0;
    restart  = 1'b0;
    case (state)
      IDLE: if (lx) begin
        state_n = RUN;
        restart = 1'b1;
      end
      RUN: begin
        if (ls && ls_cnt == CNT_LAST) begin
          state_n  = DONE;
          complete = 1'b1;
        end else if (lx) begin
          restart = 1'b1;
        end
      end
      DONE: begin
        if (lx) begin
          state_n = RUN;
          restart = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx     <= '0;
      rh     <= '0;
      rs     <= '0;
      result <= '0;
      ovf    <= 1'b0;
      ls_cnt <= '0;
    end else begin
      if (lx) rx <= x_in;
      if (lh) rh <= wdata;
      if (ls) rs <= wdata;

      if (complete) begin
        result <= wdata;
        ls_cnt <= '0;
      end else if (restart) begin
        ls_cnt <= '0;
      end else if (state == RUN && ls) begin
        ls_cnt <= ls_cnt + CNT_W'(1);
      end

      if (restart)
        ovf <= 1'b0;
      else if (state == RUN && (lh || ls) && m2 == WB_ALU && alu_ovf)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bo_datapath.sv
// Directed bench for bo_datapath: expected frame results are queued at issue time and
// checked by a monitor whenever done pulses; status outputs are checked inline.
module tb_bo_datapath;
  import bo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x_in = '0;
  logic       lx = 1'b0, ls = 1'b0, lh = 1'b0, hula = 1'b0;
  logic [1:0] m0 = '0, m1 = '0, m2 = '0;
  logic [7:0] result;
  logic       done, ovf, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;
  exp_t expq[$];

  bo_datapath #(.WIDTH(8), .C0(3), .C1(1), .LS_PER_FRAME(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .x_in   (x_in),
    .lx     (lx),
    .ls     (ls),
    .lh     (lh),
    .hula   (hula),
    .m0     (m0),
    .m1     (m1),
    .m2     (m2),
    .result (result),
    .done   (done),
    .ovf    (ovf),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ctl(input logic l_x, input logic l_s, input logic l_h, input logic op,
                     input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                     input logic [7:0] x);
    lx = l_x; ls = l_s; lh = l_h; hula = op; m0 = s0; m1 = s1; m2 = s2; x_in = x;
  endtask

  task automatic idle();
    ctl(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [7:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    expq.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 result=%0d expected no done", result);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checks++;
        if (result !== e.res || ovf !== e.ovf) begin
          failures++;
          $display("FAIL frame_result: got result=%0d ovf=%0d expected result=%0d ovf=%0d",
                   result, ovf, e.res, e.ovf);
        end
      end
    end
  end

  initial begin
    // Reset with random controls
    for (int unsigned i = 0; i < 2; i++) begin
      ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      step();
    end
    reset = 1'b0;
    idle();
    chk("reset_result", result, 0);
    chk("reset_flags", {done, ovf, busy}, 0);

    // Load/multiply: RH = 5*5, routed through RS to result
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd5); step();
    chk("lx_busy", busy, 1);
    ctl(0, 0, 1, OP_MUL, SEL_RX, SEL_RX, WB_ALU, 8'd0); step();
    chk("mul_ovf", ovf, 0);
    ctl(0, 1, 0, 0, SEL_RH, SEL_RX, WB_OPA, 8'd0); step();
    expect_done(8'd25, 1'b0);
    ctl(0, 1, 0, 0, SEL_RS, SEL_RX, WB_OPA, 8'd0); step();
    chk("done_busy_low", busy, 0);
    idle(); step();

    // Overflow then saturate
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd200); step();
    ctl(0, 1, 0, OP_ADD, SEL_RX, SEL_RX, WB_ALU, 8'd0); step();
    chk("add_ovf_set", ovf, 1);
    expect_done(8'd255, 1'b1);
    ctl(0, 1, 0, OP_ADD, SEL_RX, SEL_RX, WB_SAT, 8'd0); step();
    idle(); step();
    chk("ovf_held_idle", ovf, 1);

    // Saturation alone does not set ovf; truncating 255+1 does
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd200); step();
    chk("start_clears_ovf", ovf, 0);
    ctl(0, 0, 1, OP_ADD, SEL_RX, SEL_RX, WB_SAT, 8'd0); step();
    chk("sat_no_ovf", ovf, 0);
    ctl(0, 1, 0, 0, SEL_RH, SEL_RX, WB_OPA, 8'd0); step();
    expect_done(8'd0, 1'b1);
    ctl(0, 1, 0, OP_ADD, SEL_RS, SEL_CONST, WB_ALU, 8'd0); step();
    idle(); step();

    // Full frame: (3+1)*5
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd5); step();
    ctl(0, 1, 0, OP_ADD, SEL_CONST, SEL_CONST, WB_ALU, 8'd0); step();
    chk("mid_frame_no_done", done, 0);
    expect_done(8'd20, 1'b0);
    ctl(0, 1, 0, OP_MUL, SEL_RS, SEL_RX, WB_ALU, 8'd0); step();
    chk("done_pulse", done, 1);
    idle(); step();
    chk("done_one_cycle", {done, busy}, 0);

    // Restart in RUN clears count and ovf
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd200); step();
    ctl(0, 1, 0, OP_ADD, SEL_RX, SEL_RX, WB_ALU, 8'd0); step();
    chk("restart_pre_ovf", ovf, 1);
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd10); step();
    chk("restart_clears_ovf", {ovf, busy}, 1);
    ctl(0, 1, 0, 0, SEL_RX, SEL_RX, WB_OPA, 8'd0); step();
    chk("restart_needs_two_ls", {done, busy}, 1);
    expect_done(8'd11, 1'b0);
    ctl(0, 1, 0, OP_ADD, SEL_RS, SEL_CONST, WB_ALU, 8'd0); step();
    idle(); step();

    // lx with completing ls: completion wins, ALU sees old RX (3*3)
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd3); step();
    ctl(0, 1, 0, 0, SEL_RX, SEL_RX, WB_OPA, 8'd0); step();
    expect_done(8'd9, 1'b0);
    ctl(1, 1, 0, OP_MUL, SEL_RX, SEL_RX, WB_ALU, 8'd50); step();
    chk("simul_done", {done, busy}, 2);
    // lx in DONE starts a new frame; RX=60 read back through the frame
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd60); step();
    chk("done_to_run", busy, 1);
    ctl(0, 1, 0, 0, SEL_RX, SEL_RX, WB_OPA, 8'd0); step();
    expect_done(8'd61, 1'b0);
    ctl(0, 1, 0, OP_ADD, SEL_RS, SEL_CONST, WB_ALU, 8'd0); step();
    idle(); step();

    // Reset mid-frame
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd200); step();
    ctl(0, 1, 0, OP_ADD, SEL_RX, SEL_RX, WB_ALU, 8'd0); step();
    reset = 1'b1;
    ctl(0, 1, 0, OP_ADD, SEL_RX, SEL_RX, WB_ALU, 8'd0); step();
    reset = 1'b0;
    idle();
    chk("midreset_result", result, 0);
    chk("midreset_flags", {done, ovf, busy}, 0);
    ctl(1, 0, 0, 0, SEL_RX, SEL_RX, WB_ALU, 8'd2); step();
    ctl(0, 1, 0, OP_ADD, SEL_CONST, SEL_RH, WB_ALU, 8'd0); step();
    chk("post_reset_cnt", {done, busy}, 1);
    expect_done(8'd6, 1'b0);
    ctl(0, 1, 0, OP_MUL, SEL_RS, SEL_RX, WB_ALU, 8'd0); step();
    idle();
    for (int unsigned i = 0; i < 4; i++) step();
    chk("pending_results", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
